// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronise, frame, check, queue scan events.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into event flags.
module ps2_scan_receiver #(
  parameter int CLK_DIV    = 250,
  parameter int TIMEOUT    = 4000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  output logic [7:0]                  EVT_CODE,
  output logic                        EVT_EXT,
  output logic                        EVT_BREAK,
  output logic                        EVT_VALID,
  input  logic                        EVT_READY,
  output logic                        FRAME_ERR,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t        state_q, state_d;
  logic          ps2c_s1_q, ps2c_s2_q;
  logic          ps2d_s1_q, ps2d_s2_q;
  logic          prev_q, prev_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [9:0]    shift_q, shift_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
`ifdef PS2_PREFIX_DECODE_EN
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
`endif

  logic       tick;
  logic       fall;
  logic       frame_ok;
  logic       push;
  logic [9:0] push_data;
  logic       pop;
  logic       full;
  logic       wr_en;
  logic [9:0] head;

  always_comb begin
    tick      = (div_q == DW'(CLK_DIV - 1));
    div_d     = tick ? '0 : div_q + DW'(1);
    prev_d    = tick ? ps2c_s2_q : prev_q;
    fall      = tick & prev_q & ~ps2c_s2_q;
    frame_ok  = shift_q[9] & (^shift_q[8:0]);
    state_d   = state_q;
    bit_d     = bit_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    push_data = '0;
`ifdef PS2_PREFIX_DECODE_EN
    ext_d     = ext_q;
    brk_d     = brk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          if (!ps2d_s2_q) begin
            state_d = SHIFT;
            bit_d   = 4'd1;
            tmo_d   = '0;
            shift_d = '0;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_d = {ps2d_s2_q, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          tmo_d   = '0;
          if (bit_q == 4'd10) state_d = CHECK;
        end else if (tick) begin
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            bit_d   = '0;
            tmo_d   = '0;
            shift_d = '0;
`ifdef PS2_PREFIX_DECODE_EN
            ext_d   = 1'b0;
            brk_d   = 1'b0;
`endif
          end else begin
            tmo_d   = tmo_q + TW'(1);
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        bit_d   = '0;
        tmo_d   = '0;
        if (frame_ok) begin
`ifdef PS2_PREFIX_DECODE_EN
          if (shift_q[7:0] == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q[7:0] == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {ext_q, brk_q, shift_q[7:0]};
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end
`else
          push      = 1'b1;
          push_data = {2'b00, shift_q[7:0]};
`endif
        end else begin
          ferr_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
          ext_d  = 1'b0;
          brk_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO is only legal when the head leaves this cycle.
  always_comb begin
    head  = mem_q[rd_q];
    pop   = EVT_VALID & EVT_READY;
    full  = (lvl_q == LW'(FIFO_DEPTH));
    wr_en = push & (~full | pop);
    ovf_d = ovf_q | (push & full & ~pop);
    wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    lvl_d = lvl_q;
    if (wr_en && !pop) lvl_d = lvl_q + LW'(1);
    if (!wr_en && pop) lvl_d = lvl_q - LW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      ps2c_s1_q <= 1'b1;
      ps2c_s2_q <= 1'b1;
      ps2d_s1_q <= 1'b1;
      ps2d_s2_q <= 1'b1;
      prev_q    <= 1'b1;
      div_q     <= '0;
      bit_q     <= '0;
      tmo_q     <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ps2c_s1_q <= PS2_CLK;
      ps2c_s2_q <= ps2c_s1_q;
      ps2d_s1_q <= PS2_DATA;
      ps2d_s2_q <= ps2d_s1_q;
      prev_q    <= prev_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      if (wr_en) mem_q[wr_q] <= push_data;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q     <= ext_d;
      brk_q     <= brk_d;
`endif
    end
  end

  assign EVT_VALID  = RST_N & (lvl_q != '0);
  assign EVT_CODE   = EVT_VALID ? head[7:0] : 8'h00;
  assign EVT_BREAK  = EVT_VALID & head[8];
  assign EVT_EXT    = EVT_VALID & head[9];
  assign FRAME_ERR  = ferr_q;
  assign OVERFLOW   = ovf_q;
  assign FIFO_LEVEL = lvl_q;

endmodule
